// File: rtl/ps2_scancode_receiver_if.sv
// Scancode bus from the PS/2 receiver to the keyboard command controller.
interface ps2_scancode_receiver_if;
  logic [7:0] scancode;
  logic       valid;
  logic       extended;
  logic       break_code;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output scancode,
    output valid,
    output extended,
    output break_code,
    output parity_error,
    output frame_error
  );

  modport slave (
    input scancode,
    input valid,
    input extended,
    input break_code,
    input parity_error,
    input frame_error
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser,
// parity/framing checks and optional E0/F0 prefix and break stripping.
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned SUPPRESS_BREAK = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2_clock,
  input  logic                    ps2_data,
  ps2_scancode_receiver_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          SUPPRESS = (SUPPRESS_BREAK != 0);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [3:0]    filt_cnt;
  logic          fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          ext_flag;
  logic          brk_flag;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]    scancode_q;
  logic          valid_q;
  logic          extended_q;
  logic          break_q;
  logic          perr_q;
  logic          ferr_q;

  logic          is_e0;
  logic          is_f0;
  logic          par_ok;
  logic          emit;

  // Two-flop synchronisers on both raw pins; idle level of the bus is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Deglitch the clock: change level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == 4'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Frame classification of the byte held in the shifter at the stop bit.
  always_comb begin
    is_e0  = (shift == 8'hE0);
    is_f0  = (shift == 8'hF0);
    par_ok = ^{par_bit, shift};
    emit   = !SUPPRESS || (!is_e0 && !is_f0 && !brk_flag);
  end

  // Frame FSM, timeout supervision, prefix tracking and output pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      tmo_cnt    <= '0;
      scancode_q <= '0;
      valid_q    <= 1'b0;
      extended_q <= 1'b0;
      break_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      // A fall event takes precedence over an expiring timeout in the same cycle.
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_sync[1]) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_sync[1], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= dat_sync[1];
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_sync[1]) begin
              ferr_q   <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end else if (!par_ok) begin
              perr_q   <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end else begin
              if (emit) begin
                valid_q    <= 1'b1;
                scancode_q <= shift;
                extended_q <= ext_flag;
                break_q    <= SUPPRESS ? 1'b0 : brk_flag;
              end
              if (is_e0) begin
                ext_flag <= 1'b1;
              end else if (is_f0) begin
                brk_flag <= 1'b1;
              end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state    <= IDLE;
          tmo_cnt  <= '0;
          ferr_q   <= 1'b1;
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.scancode     = scancode_q;
  assign bus.valid        = valid_q;
  assign bus.extended     = extended_q;
  assign bus.break_code   = break_q;
  assign bus.parity_error = perr_q;
  assign bus.frame_error  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench: two receivers (break suppression on/off) share the PS/2 pins;
// expected pulses are queued when each frame's stop bit is driven.
module tb_ps2_scancode_receiver;

  localparam int FL  = 4;
  localparam int TMO = 300;
  localparam int H   = 40;   // half period of the PS/2 clock in system cycles

  logic clock     = 1'b0;
  logic reset     = 1'b0;
  logic ps2_clock = 1'b1;
  logic ps2_data  = 1'b1;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  ps2_scancode_receiver_if bus_s();
  ps2_scancode_receiver_if bus_n();

  ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .SUPPRESS_BREAK(1)) dut_s (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data), .bus(bus_s));

  ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .SUPPRESS_BREAK(0)) dut_n (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data), .bus(bus_n));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;   // {valid, parity_error, frame_error}
    logic [7:0] code;
    logic       ext;
    logic       brk;
    int         cyc;
  } ev_t;

  ev_t q_s[$];
  ev_t q_n[$];

  // Model state, index 0 = no suppression, 1 = suppression.
  logic       m_ext[2];
  logic       m_brk[2];
  logic [7:0] h_code[2];
  logic       h_ext[2];
  logic       h_brk[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ext[m] = 1'b0; m_brk[m] = 1'b0;
      h_code[m] = 8'h00; h_ext[m] = 1'b0; h_brk[m] = 1'b0;
    end
  endtask

  task automatic push(input int m, input logic [2:0] kind, input int cyc_exp);
    ev_t e;
    e.kind = kind; e.code = h_code[m]; e.ext = h_ext[m]; e.brk = h_brk[m]; e.cyc = cyc_exp;
    if (m == 1) q_s.push_back(e);
    else        q_n.push_back(e);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int cyc_exp);
    for (int m = 0; m < 2; m++) begin
      bit pre;
      pre = (b == 8'hE0) || (b == 8'hF0);
      if (bad_stop) begin
        m_ext[m] = 1'b0; m_brk[m] = 1'b0;
        push(m, 3'b001, cyc_exp);
      end else if (bad_par) begin
        m_ext[m] = 1'b0; m_brk[m] = 1'b0;
        push(m, 3'b010, cyc_exp);
      end else begin
        if (m == 0 || (!pre && !m_brk[m])) begin
          h_code[m] = b;
          h_ext[m]  = m_ext[m];
          h_brk[m]  = (m == 0) ? m_brk[m] : 1'b0;
          push(m, 3'b100, cyc_exp);
        end
        if (b == 8'hE0)      m_ext[m] = 1'b1;
        else if (b == 8'hF0) m_brk[m] = 1'b1;
        else begin m_ext[m] = 1'b0; m_brk[m] = 1'b0; end
      end
    end
  endtask

  task automatic model_timeout(input int cyc_exp);
    for (int m = 0; m < 2; m++) begin
      m_ext[m] = 1'b0; m_brk[m] = 1'b0;
      push(m, 3'b001, cyc_exp);
    end
  endtask

  task automatic observe(input int m, input logic [2:0] kind, input logic [7:0] code,
                         input logic ext, input logic brk);
    ev_t   e;
    string p;
    int    sz;
    p  = (m == 1) ? "S" : "N";
    sz = (m == 1) ? q_s.size() : q_n.size();
    if (sz == 0) begin
      check({p, "_spurious_pulse"}, {29'd0, kind}, 32'd0);
      return;
    end
    if (m == 1) e = q_s.pop_front();
    else        e = q_n.pop_front();
    check({p, "_kind"},     {29'd0, kind}, {29'd0, e.kind});
    check({p, "_scancode"}, {24'd0, code}, {24'd0, e.code});
    check({p, "_extended"}, {31'd0, ext},  {31'd0, e.ext});
    check({p, "_break"},    {31'd0, brk},  {31'd0, e.brk});
    check({p, "_latency"},  cyc,           e.cyc);
  endtask

  always @(negedge clock) begin
    if (bus_s.valid || bus_s.parity_error || bus_s.frame_error)
      observe(1, {bus_s.valid, bus_s.parity_error, bus_s.frame_error},
              bus_s.scancode, bus_s.extended, bus_s.break_code);
    if (bus_n.valid || bus_n.parity_error || bus_n.frame_error)
      observe(0, {bus_n.valid, bus_n.parity_error, bus_n.frame_error},
              bus_n.scancode, bus_n.extended, bus_n.break_code);
  end

  task automatic check_outs_zero(input string tag);
    check({"S_", tag}, {18'd0, bus_s.scancode, bus_s.valid, bus_s.extended, bus_s.break_code,
                        bus_s.parity_error, bus_s.frame_error}, 32'd0);
    check({"N_", tag}, {18'd0, bus_n.scancode, bus_n.valid, bus_n.extended, bus_n.break_code,
                        bus_n.parity_error, bus_n.frame_error}, 32'd0);
  endtask

  // Drives nbits of a frame; glitch_bit inserts a 2-cycle low pulse in that bit's
  // high phase; reset_after pulses reset for one cycle after that many bits.
  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                      input int nbits, input int glitch_bit, input int reset_after,
                      output int last_fall);
    logic [10:0] v;
    v = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_data = v[i];
      if (i == glitch_bit) begin
        repeat (H / 2) @(negedge clock);
        ps2_clock = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clock = 1'b1;
        repeat (H / 2 - 2) @(negedge clock);
      end else begin
        repeat (H) @(negedge clock);
      end
      ps2_clock = 1'b0;
      last_fall = cyc;
      if (i == 10) model_frame(b, bad_par, bad_stop, cyc + FL + 3);
      repeat (H) @(negedge clock);
      ps2_clock = 1'b1;
      if (i + 1 == reset_after) begin
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        ps2_data = 1'b1;
        return;
      end
    end
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (H) @(negedge clock);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lf;
    model_reset();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_outs_zero("reset_outputs");
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // Short low glitch while idle must not start a frame.
    ps2_clock = 1'b0;
    repeat (2) @(negedge clock);
    ps2_clock = 1'b1;
    repeat (20) @(negedge clock);

    send(8'h5A, 0, 0, 11, -1, -1, lf);
    send(8'hF0, 0, 0, 11, -1, -1, lf);
    send(8'h5A, 0, 0, 11, -1, -1, lf);
    send(8'h16, 0, 0, 11, -1, -1, lf);
    send(8'hE0, 0, 0, 11, -1, -1, lf);
    send(8'h75, 0, 0, 11, -1, -1, lf);
    send(8'h75, 0, 0, 11, -1, -1, lf);
    send(8'h45, 1, 0, 11, -1, -1, lf);
    send(8'h45, 0, 0, 11, -1, -1, lf);
    send(8'hE0, 0, 0, 11, -1, -1, lf);
    send(8'h12, 0, 1, 11, -1, -1, lf);
    send(8'h75, 0, 0, 11, -1, -1, lf);

    // Prefix then a truncated frame: timeout clears it.
    send(8'hE0, 0, 0, 11, -1, -1, lf);
    send(8'h3C, 0, 0, 5, -1, -1, lf);
    model_timeout(lf + FL + 3 + TMO);
    repeat (TMO + 50) @(negedge clock);
    send(8'h2D, 0, 0, 11, -1, -1, lf);

    send(8'h1C, 0, 0, 11, 3, -1, lf);

    send(8'h29, 0, 0, 11, -1, 6, lf);
    @(negedge clock);
    check_outs_zero("mid_frame_reset");
    repeat (20) @(negedge clock);
    send(8'h29, 0, 0, 11, -1, -1, lf);

    repeat (100) @(negedge clock);
    check("S_pending_events", q_s.size(), 32'd0);
    check("N_pending_events", q_n.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
